// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_pkg;

   typedef enum logic [1:0] {
      WAIT_REL,
      IDLE,
      PRESSED,
      LONG_HELD
   } btn_state_t;

   localparam int unsigned BTN_LONG_CNT_DEF   = 50_000_000;
   localparam int unsigned BTN_REPEAT_CNT_DEF = 12_500_000;

endpackage

// File: rtl/btn_event_decoder_mod_wrap_cnt.sv
// Enable-driven mode index counter, wraps from NUM_MODES-1 back to 0.
module mod_wrap_cnt
   import btn_pkg::*;
#(
   parameter int unsigned NUM_MODES = 4,
   parameter int unsigned SEL_W     = $clog2(NUM_MODES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [SEL_W-1:0] cnt
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_MODES - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + SEL_W'(1);
      end
   end

endmodule

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into press/release/short/long/repeat events.
// Auto-repeat is built only when BTN_DECODER_AUTOREPEAT_EN is defined.
module btn_event_decoder
   import btn_pkg::*;
#(
   parameter int unsigned LONG_CNT   = BTN_LONG_CNT_DEF,
   parameter int unsigned REPEAT_CNT = BTN_REPEAT_CNT_DEF,
   parameter int unsigned NUM_MODES  = 4,
   localparam int unsigned SEL_W     = $clog2(NUM_MODES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stbl,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic             short_pulse,
   output logic             long_pulse,
   output logic             repeat_pulse,
   output logic             held,
   output logic [SEL_W-1:0] sel,
   output logic             bypass
);

   localparam int unsigned HOLD_W = $clog2(LONG_CNT) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

   if (LONG_CNT < 2 || REPEAT_CNT < 1 || NUM_MODES < 2) begin : g_bad_param
      $error("btn_event_decoder: invalid parameters");
   end

   btn_state_t        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              press_d, rel_d, short_d, long_d, repeat_d;
   logic              repeat_q, bypass_d;

`ifdef BTN_DECODER_AUTOREPEAT_EN
   localparam int unsigned RPT_W = $clog2(REPEAT_CNT) + 1;
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CNT - 1);
   localparam logic [RPT_W-1:0] RPT_MAX  = '1;

   logic [RPT_W-1:0] rpt_q, rpt_d;

   always_ff @(posedge clk) begin
      if (rst) rpt_q <= '0;
      else     rpt_q <= rpt_d;
   end
`endif

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      short_d  = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      bypass_d = bypass;
`ifdef BTN_DECODER_AUTOREPEAT_EN
      rpt_d    = rpt_q;
`endif
      unique case (state_q)
         WAIT_REL: begin
            if (!stbl) state_d = IDLE;
         end
         IDLE: begin
            if (stbl) begin
               state_d = PRESSED;
               press_d = 1'b1;
               hold_d  = '0;
            end
         end
         PRESSED: begin
            // a release on the threshold edge still counts as short
            if (!stbl) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               short_d = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               state_d  = LONG_HELD;
               long_d   = 1'b1;
               bypass_d = ~bypass;
`ifdef BTN_DECODER_AUTOREPEAT_EN
               rpt_d    = '0;
`endif
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         LONG_HELD: begin
            if (!stbl) begin
               state_d = IDLE;
               rel_d   = 1'b1;
            end
`ifdef BTN_DECODER_AUTOREPEAT_EN
            else if (rpt_q == RPT_LAST) begin
               rpt_d    = '0;
               repeat_d = 1'b1;
            end else if (rpt_q != RPT_MAX) begin
               rpt_d = rpt_q + RPT_W'(1);
            end
`endif
         end
         default: state_d = WAIT_REL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= WAIT_REL;
         hold_q        <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_q      <= 1'b0;
         bypass        <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         press_pulse   <= press_d;
         release_pulse <= rel_d;
         short_pulse   <= short_d;
         long_pulse    <= long_d;
         repeat_q      <= repeat_d;
         bypass        <= bypass_d;
      end
   end

   assign repeat_pulse = repeat_q;
   assign held = (state_q == PRESSED) || (state_q == LONG_HELD);

   // next-cycle enable keeps sel aligned with its short/repeat pulse
   mod_wrap_cnt #(
      .NUM_MODES (NUM_MODES),
      .SEL_W     (SEL_W)
   ) u_sel (
      .clk (clk),
      .rst (rst),
      .en  (short_d | repeat_d),
      .cnt (sel)
   );

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder (LONG_CNT=8, REPEAT_CNT=3, NUM_MODES=3).
module tb_btn_event_decoder;

`ifdef BTN_DECODER_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stbl = 1'b1;
   logic       press_pulse, release_pulse, short_pulse;
   logic       long_pulse, repeat_pulse, held, bypass;
   logic [1:0] sel;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_sel;
   bit exp_byp;

   typedef struct packed {
      logic       stbl;
      logic       press;
      logic       rel;
      logic       shrt;
      logic       lng;
      logic       rpt;
      logic       held;
      logic [1:0] sel;
      logic       byp;
   } vec_t;

   vec_t tbl[$];

   btn_event_decoder #(
      .LONG_CNT   (8),
      .REPEAT_CNT (3),
      .NUM_MODES  (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stbl          (stbl),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .short_pulse   (short_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse),
      .held          (held),
      .sel           (sel),
      .bypass        (bypass)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic s, logic p, logic r, logic sh,
                               logic l, logic rp, logic h,
                               logic [1:0] se, logic b);
      vec_t v;
      v.stbl = s; v.press = p; v.rel = r; v.shrt = sh;
      v.lng = l; v.rpt = rp; v.held = h; v.sel = se; v.byp = b;
      return v;
   endfunction

   task automatic chk1(string tag, string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0d, expected %0d", tag, nm, act, exp);
      end
   endtask

   task automatic check_out(vec_t e, string tag);
      chk1(tag, "press_pulse", int'(press_pulse), int'(e.press));
      chk1(tag, "release_pulse", int'(release_pulse), int'(e.rel));
      chk1(tag, "short_pulse", int'(short_pulse), int'(e.shrt));
      chk1(tag, "long_pulse", int'(long_pulse), int'(e.lng));
      chk1(tag, "repeat_pulse", int'(repeat_pulse), int'(e.rpt));
      chk1(tag, "held", int'(held), int'(e.held));
      chk1(tag, "sel", int'(sel), int'(e.sel));
      chk1(tag, "bypass", int'(bypass), int'(e.byp));
   endtask

   task automatic step(logic v);
      @(negedge clk);
      stbl = v;
      @(posedge clk);
      #1;
   endtask

   task automatic short_press(string tag);
      step(1'b1);
      check_out(mk(1, 1, 0, 0, 0, 0, 1, 2'(exp_sel), exp_byp), tag);
      step(1'b0);
      exp_sel = (exp_sel + 1) % 3;
      check_out(mk(0, 0, 1, 1, 0, 0, 0, 2'(exp_sel), exp_byp), tag);
   endtask

   task automatic reach_long(string tag);
      step(1'b1);
      check_out(mk(1, 1, 0, 0, 0, 0, 1, 2'(exp_sel), exp_byp), tag);
      for (int k = 1; k <= 8; k++) begin
         step(1'b1);
         if (k == 8) exp_byp = ~exp_byp;
         check_out(mk(1, 0, 0, 0, k == 8, 0, 1, 2'(exp_sel), exp_byp), tag);
      end
   endtask

   initial begin
      // test 1-3 vectors: {stbl, press, rel, short, long, rpt, held, sel, byp}
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2'd0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2'd0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2'd1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2'd1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2'd1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2'd1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 2'd2, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2'd2, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2'd2, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2'd0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2'd0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2'd1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2'd1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 2'd2, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 0));

      rst  = 1'b1;
      stbl = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_out(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0), "reset");

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1);
         check_out(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0), "held_thru_rst");
      end

      foreach (tbl[i]) begin
         step(tbl[i].stbl);
         check_out(tbl[i], $sformatf("vec%0d", i));
      end

      exp_sel = 2;
      exp_byp = 1'b0;

      step(1'b1);
      check_out(mk(1, 1, 0, 0, 0, 0, 1, 2'(exp_sel), exp_byp), "long_press");
      for (int k = 1; k <= 20; k++) begin
         bit l, r;
         step(1'b1);
         l = (k == 8);
         r = AR && (k > 8) && ((k - 8) % 3 == 0);
         if (l) exp_byp = ~exp_byp;
         if (r) exp_sel = (exp_sel + 1) % 3;
         check_out(mk(1, 0, 0, 0, l, r, 1, 2'(exp_sel), exp_byp),
                   $sformatf("long_k%0d", k));
      end
      step(1'b0);
      check_out(mk(0, 0, 1, 0, 0, 0, 0, 2'(exp_sel), exp_byp), "long_release");
      step(1'b0);
      check_out(mk(0, 0, 0, 0, 0, 0, 0, 2'(exp_sel), exp_byp), "long_idle");

      step(1'b1);
      check_out(mk(1, 1, 0, 0, 0, 0, 1, 2'(exp_sel), exp_byp), "edge_press");
      for (int k = 1; k <= 7; k++) begin
         step(1'b1);
         check_out(mk(1, 0, 0, 0, 0, 0, 1, 2'(exp_sel), exp_byp), "edge_hold");
      end
      step(1'b0);
      exp_sel = (exp_sel + 1) % 3;
      check_out(mk(0, 0, 1, 1, 0, 0, 0, 2'(exp_sel), exp_byp), "edge_release");
      step(1'b0);
      check_out(mk(0, 0, 0, 0, 0, 0, 0, 2'(exp_sel), exp_byp), "edge_idle");

      for (int i = 0; i < 3; i++) begin
         if (exp_sel == 2) break;
         short_press("to_sel2");
      end
      reach_long("long_a");
      step(1'b0);
      check_out(mk(0, 0, 1, 0, 0, 0, 0, 2'(exp_sel), exp_byp), "long_a_rel");
      reach_long("long_b");
      chk1("pre_rst", "sel", int'(sel), 2);
      chk1("pre_rst", "bypass", int'(bypass), 1);

      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_out(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0), "mid_hold_rst");
      @(negedge clk);
      rst = 1'b0;
      step(1'b1);
      check_out(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0), "post_rst_wait");
      step(1'b1);
      check_out(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0), "post_rst_wait2");
      step(1'b0);
      check_out(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0), "post_rst_idle");
      step(1'b1);
      check_out(mk(1, 1, 0, 0, 0, 0, 1, 2'd0, 0), "post_rst_press");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
